vga_sync_gen: RTL and testbench

//  Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/pixel_tick_div.sv | 29 ++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing defaults shared by the sync generator.
// Derived sync windows are inclusive pixel/line ranges.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int CLK_DIV   = 4;

    localparam int H_TOTAL =
        H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL =
        V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clock pixel-enable strobe.
// p_tick is forced low while reset is held.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW =
        (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign p_tick = (div_cnt == LAST) && !reset;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA line/frame counters with registered, mutually aligned sync outputs.
// Define VGA_SYNC_FRAME_CNT_EN to enable the completed-frame counter.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixelx,
    output logic [CNT_W-1:0] pixely,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOT =
        H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT =
        V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_DISPLAY);
    localparam cnt_t V_VIS  = cnt_t'(V_DISPLAY);
    localparam cnt_t HS_LO  = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_HI  =
        cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_LO  = cnt_t'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_HI  =
        cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    cnt_t x_n;
    cnt_t y_n;
    logic line_end;
    logic frame_end;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign line_end  = (pixelx == H_LAST);
    assign frame_end = line_end && (pixely == V_LAST);

    always_comb begin
        x_n = pixelx + cnt_t'(1);
        y_n = pixely;
        if (line_end) begin
            x_n = '0;
            y_n = frame_end ? '0 : pixely + cnt_t'(1);
        end
    end

    // Decode from the next count so flags line up with pixelx/pixely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelx      <= '0;
            pixely      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (p_tick) begin
            pixelx      <= x_n;
            pixely      <= y_n;
            hsync       <= !((x_n >= HS_LO) && (x_n <= HS_HI));
            vsync       <= !((y_n >= VS_LO) && (y_n <= VS_HI));
            video_on    <= (x_n < H_VIS) && (y_n < V_VIS);
            frame_start <= (x_n == '0) && (y_n == '0);
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'h00;
        end else if (p_tick && frame_end) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, CLK_DIV=1, tiny timing)
// checked each clock against an arithmetic tick-count model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       frame_start;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
    } obs_t;

    localparam obs_t RST_VAL = '{
        p_tick: 1'b0, hsync: 1'b1, vsync: 1'b1,
        video_on: 1'b0, frame_start: 1'b0,
        x: 10'd0, y: 10'd0, fc: 8'd0
    };

    // tiny timing for the multi-frame run
    localparam int MH_D = 8;
    localparam int MH_F = 2;
    localparam int MH_S = 3;
    localparam int MH_B = 2;
    localparam int MV_D = 6;
    localparam int MV_F = 1;
    localparam int MV_S = 2;
    localparam int MV_B = 2;
    localparam int M_FRAME =
        (MH_D + MH_F + MH_S + MH_B) * (MV_D + MV_F + MV_S + MV_B);

    logic clk = 1'b0;
    logic rst_std = 1'b1;
    logic rst_fast = 1'b1;
    logic rst_mini = 1'b1;

    int total = 0;
    int bad = 0;
    int c_std = 0;

    logic hs_a, vs_a, von_a, pt_a, fs_a;
    logic hs_b, vs_b, von_b, pt_b, fs_b;
    logic hs_c, vs_c, von_c, pt_c, fs_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [7:0] fc_a, fc_b, fc_c;
    obs_t o_std, o_fast, o_mini;

    always #5 clk = ~clk;

    vga_sync_gen u_std (
        .clk(clk), .reset(rst_std),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .p_tick(pt_a), .pixelx(x_a), .pixely(y_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_fast (
        .clk(clk), .reset(rst_fast),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .p_tick(pt_b), .pixelx(x_b), .pixely(y_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    vga_sync_gen #(
        .H_DISPLAY(MH_D), .H_FRONT(MH_F),
        .H_SYNC(MH_S), .H_BACK(MH_B),
        .V_DISPLAY(MV_D), .V_FRONT(MV_F),
        .V_SYNC(MV_S), .V_BACK(MV_B),
        .CLK_DIV(1)
    ) u_mini (
        .clk(clk), .reset(rst_mini),
        .hsync(hs_c), .vsync(vs_c), .video_on(von_c),
        .p_tick(pt_c), .pixelx(x_c), .pixely(y_c),
        .frame_start(fs_c), .frame_count(fc_c)
    );

    assign o_std  = {pt_a, hs_a, vs_a, von_a, fs_a, x_a, y_a, fc_a};
    assign o_fast = {pt_b, hs_b, vs_b, von_b, fs_b, x_b, y_b, fc_b};
    assign o_mini = {pt_c, hs_c, vs_c, von_c, fs_c, x_c, y_c, fc_c};

    // c = clock edges since reset release; t = pixel ticks consumed.
    function automatic obs_t model(
        input int c, input int d,
        input int hd, input int hf, input int hs, input int hb,
        input int vd, input int vf, input int vs, input int vb
    );
        obs_t o;
        int ht, vt, t, x, y;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t = c / d;
        x = t % ht;
        y = (t / ht) % vt;
        o.p_tick = ((c % d) == (d - 1));
        o.hsync = !(x >= hd + hf && x < hd + hf + hs);
        o.vsync = !(y >= vd + vf && y < vd + vf + vs);
        o.video_on = (t > 0) && (x < hd) && (y < vd);
        o.frame_start = (t > 0) && (x == 0) && (y == 0);
        o.x = 10'(x);
        o.y = 10'(y);
`ifdef VGA_SYNC_FRAME_CNT_EN
        o.fc = 8'((t / (ht * vt)) % 256);
`else
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    function automatic obs_t m_std(input int c);
        return model(c, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t m_fast(input int c);
        return model(c, 1, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t m_mini(input int c);
        return model(c, 1, MH_D, MH_F, MH_S, MH_B,
                     MV_D, MV_F, MV_S, MV_B);
    endfunction

    task automatic test_reset();
        obs_t e;
        repeat (5) begin
            @(posedge clk); #1;
            total++;
            if (o_std !== RST_VAL) begin
                bad++;
                $display("FAIL reset_hold got=%h want=%h",
                         o_std, RST_VAL);
            end
        end
        @(negedge clk);
        rst_std = 1'b0;
        c_std = 0;
        #1;
        e = m_std(c_std);
        total++;
        if (o_std !== e) begin
            bad++;
            $display("FAIL release got=%h want=%h", o_std, e);
        end
        repeat (12) begin
            @(posedge clk); #1;
            c_std++;
            e = m_std(c_std);
            total++;
            if (o_std !== e) begin
                bad++;
                $display("FAIL first_ticks c=%0d got=%h want=%h",
                         c_std, o_std, e);
            end
            if (c_std == 4) begin
                total++;
                if (x_a !== 10'd1 || von_a !== 1'b1) begin
                    bad++;
                    $display("FAIL first_pixel x=%0d von=%b want 1/1",
                             x_a, von_a);
                end
            end
        end
    endtask

    task automatic test_line();
        obs_t e, prev;
        int hs_lo = 0;
        int fall_x = -1;
        int rise_x = -1;
        int von_x = -1;
        int ystep = 0;
        prev = o_std;
        while (c_std < 800 * 4 + 8) begin
            @(posedge clk); #1;
            c_std++;
            e = m_std(c_std);
            total++;
            if (o_std !== e) begin
                bad++;
                $display("FAIL line c=%0d got=%h want=%h",
                         c_std, o_std, e);
            end
            if (pt_a && !hs_a) hs_lo++;
            if (prev.hsync && !hs_a) fall_x = int'(x_a);
            if (!prev.hsync && hs_a) rise_x = int'(x_a);
            if (prev.video_on && !von_a && von_x < 0)
                von_x = int'(x_a);
            if (prev.x == 10'd799 && x_a == 10'd0 && y_a == 10'd1)
                ystep++;
            prev = o_std;
        end
        total++;
        if (hs_lo != 96) begin
            bad++;
            $display("FAIL hsync_width got=%0d want=96", hs_lo);
        end
        total++;
        if (fall_x != 656 || rise_x != 752) begin
            bad++;
            $display("FAIL hsync_edges got=%0d/%0d want=656/752",
                     fall_x, rise_x);
        end
        total++;
        if (von_x != 640) begin
            bad++;
            $display("FAIL video_off_x got=%0d want=640", von_x);
        end
        total++;
        if (ystep != 1) begin
            bad++;
            $display("FAIL line_wrap got=%0d want=1", ystep);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        int tgt_c, hold, run;
        tgt_c = (800 + int'($urandom_range(656, 751))) * 4
              + int'($urandom_range(0, 3));
        while (c_std < tgt_c) begin
            @(posedge clk); #1;
            c_std++;
            e = m_std(c_std);
            total++;
            if (o_std !== e) begin
                bad++;
                $display("FAIL pre_reset c=%0d got=%h want=%h",
                         c_std, o_std, e);
            end
        end
        total++;
        if (hs_a !== 1'b0 || y_a !== 10'd1) begin
            bad++;
            $display("FAIL pre_reset_pos hs=%b y=%0d want 0/1",
                     hs_a, y_a);
        end
        #1;
        rst_std = 1'b1;
        #1;
        total++;
        if (o_std !== RST_VAL) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h",
                     o_std, RST_VAL);
        end
        hold = int'($urandom_range(1, 3));
        repeat (hold) begin
            @(posedge clk); #1;
            total++;
            if (o_std !== RST_VAL) begin
                bad++;
                $display("FAIL mid_hold got=%h want=%h",
                         o_std, RST_VAL);
            end
        end
        @(negedge clk);
        rst_std = 1'b0;
        c_std = 0;
        run = int'($urandom_range(40, 200));
        repeat (run) begin
            @(posedge clk); #1;
            c_std++;
            e = m_std(c_std);
            total++;
            if (o_std !== e) begin
                bad++;
                $display("FAIL restart c=%0d got=%h want=%h",
                         c_std, o_std, e);
            end
        end
        rst_std = 1'b1;
    endtask

    task automatic test_clkdiv1();
        obs_t e;
        int c = 0;
        int hs_lo = 0;
        int wrap_c = -1;
        @(negedge clk);
        rst_fast = 1'b0;
        #1;
        e = m_fast(0);
        total++;
        if (o_fast !== e) begin
            bad++;
            $display("FAIL div1_release got=%h want=%h", o_fast, e);
        end
        repeat (1000) begin
            @(posedge clk); #1;
            c++;
            e = m_fast(c);
            total++;
            if (o_fast !== e) begin
                bad++;
                $display("FAIL div1 c=%0d got=%h want=%h",
                         c, o_fast, e);
            end
            if (c < 800 && !hs_b) hs_lo++;
            if (wrap_c < 0 && x_b == 10'd0 && y_b == 10'd1)
                wrap_c = c;
        end
        total++;
        if (hs_lo != 96) begin
            bad++;
            $display("FAIL div1_hsync got=%0d want=96", hs_lo);
        end
        total++;
        if (wrap_c != 800) begin
            bad++;
            $display("FAIL div1_line got=%0d want=800", wrap_c);
        end
        rst_fast = 1'b1;
    endtask

    task automatic test_frames();
        obs_t e;
        int c = 0;
        int fs_n = 0;
        int vs_n = 0;
        int last;
        logic [7:0] fc_want;
        last = 257 * M_FRAME + int'($urandom_range(0, 20));
        @(negedge clk);
        rst_mini = 1'b0;
        while (c < last) begin
            @(posedge clk); #1;
            c++;
            e = m_mini(c);
            total++;
            if (o_mini !== e) begin
                bad++;
                $display("FAIL frames c=%0d got=%h want=%h",
                         c, o_mini, e);
            end
            if (fs_c) fs_n++;
            if (!vs_c) vs_n++;
        end
        total++;
        if (fs_n != 257) begin
            bad++;
            $display("FAIL frame_start_n got=%0d want=257", fs_n);
        end
        total++;
        if (vs_n != 257 * MV_S * (MH_D + MH_F + MH_S + MH_B)) begin
            bad++;
            $display("FAIL vsync_clks got=%0d want=%0d", vs_n,
                     257 * MV_S * (MH_D + MH_F + MH_S + MH_B));
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        fc_want = 8'h01;
`else
        fc_want = 8'h00;
`endif
        total++;
        if (fc_c !== fc_want) begin
            bad++;
            $display("FAIL frame_count got=%h want=%h",
                     fc_c, fc_want);
        end
        rst_mini = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line();
        test_reset_mid();
        test_clkdiv1();
        test_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
